// File: rtl/bc_broadcast_buffer.sv
// Source end of the lane broadcast chain: stores a command's operand vector once,
// replays it into lane 0 and checks the words coming back from the last lane.
module bc_broadcast_buffer #(
    parameter int unsigned Depth = 8,
    parameter int unsigned RepW  = 8,
    parameter int unsigned ELEN  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [$clog2(Depth):0] cmd_len_i,
    input  logic [RepW-1:0]        cmd_reps_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [ELEN-1:0]        in_data_i,
    output logic                   bc_valid_o,
    input  logic                   bc_ready_i,
    output logic [ELEN-1:0]        bc_data_o,
    input  logic                   ret_valid_i,
    output logic                   ret_ready_o,
    input  logic [ELEN-1:0]        ret_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int unsigned IdxW  = $clog2(Depth);
    localparam int unsigned LenW  = IdxW + 1;
    localparam int unsigned PassW = RepW + 1;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e            state_q, state_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [RepW-1:0]   reps_q, reps_d;
    logic [LenW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LenW-1:0]   rd_idx_q, rd_idx_d;
    logic [PassW-1:0]  rd_pass_q, rd_pass_d;
    logic [LenW-1:0]   ret_idx_q, ret_idx_d;
    logic [PassW-1:0]  ret_pass_q, ret_pass_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [ELEN-1:0]   mem_q [Depth];

    logic              active;
    logic              in_fire, bc_fire, ret_fire;
    logic              ret_mismatch;
    logic [LenW-1:0]   last_idx;

    assign active      = (state_q == ACTIVE);
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = active;
    assign in_ready_o  = active && (wr_cnt_q < len_q);
    // Later passes always see rd_idx < wr_cnt since the fill completed in pass 0.
    assign bc_valid_o  = active && (rd_pass_q <= PassW'(reps_q)) && (rd_idx_q < wr_cnt_q);
    assign ret_ready_o = active;
    assign bc_data_o   = mem_q[rd_idx_q[IdxW-1:0]];
    assign done_o      = done_q;
    assign err_o       = err_q;

    assign in_fire      = in_valid_i && in_ready_o;
    assign bc_fire      = bc_valid_o && bc_ready_i;
    assign ret_fire     = ret_valid_i && ret_ready_o;
    assign ret_mismatch = (ret_data_i != mem_q[ret_idx_q[IdxW-1:0]]);
    assign last_idx     = len_q - LenW'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        reps_d     = reps_q;
        wr_cnt_d   = wr_cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_pass_d  = rd_pass_q;
        ret_idx_d  = ret_idx_q;
        ret_pass_d = ret_pass_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    len_d      = cmd_len_i;
                    reps_d     = cmd_reps_i;
                    wr_cnt_d   = '0;
                    rd_idx_d   = '0;
                    rd_pass_d  = '0;
                    ret_idx_d  = '0;
                    ret_pass_d = '0;
                    err_d      = 1'b0;
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (in_fire) begin
                    wr_cnt_d = wr_cnt_q + LenW'(1);
                end
                if (bc_fire) begin
                    if (rd_idx_q == last_idx) begin
                        rd_idx_d  = '0;
                        rd_pass_d = rd_pass_q + PassW'(1);
                    end else begin
                        rd_idx_d = rd_idx_q + LenW'(1);
                    end
                end
                if (ret_fire) begin
                    if (ret_mismatch) begin
                        err_d = 1'b1;
                    end
                    if (ret_idx_q == last_idx) begin
                        ret_idx_d  = '0;
                        ret_pass_d = ret_pass_q + PassW'(1);
                        if (ret_pass_q == PassW'(reps_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ret_idx_d = ret_idx_q + LenW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            reps_q     <= '0;
            wr_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_pass_q  <= '0;
            ret_idx_q  <= '0;
            ret_pass_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            reps_q     <= reps_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_pass_q  <= rd_pass_d;
            ret_idx_q  <= ret_idx_d;
            ret_pass_q <= ret_pass_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Storage is write-once per command, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem_q[wr_cnt_q[IdxW-1:0]] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_bc_broadcast_buffer.sv
// Bench for bc_broadcast_buffer: command table, hand-written corner sequences and
// random commands, all checked against a word-stream model of the chain.
module tb_bc_broadcast_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned REPW  = 8;
    localparam int unsigned ELEN  = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [3:0]      cmd_len_i;
    logic [7:0]      cmd_reps_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [63:0]     in_data_i;
    logic            bc_valid_o;
    logic            bc_ready_i;
    logic [63:0]     bc_data_o;
    logic            ret_valid_i;
    logic            ret_ready_o;
    logic [63:0]     ret_data_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int          len;
        int          reps;
        logic [63:0] base;
        int          bc_mode;
        int          fill_mode;
        int          corrupt;
        int          delay;
        int          exp_sends;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        int          due;
    } flight_t;

    bc_broadcast_buffer #(.Depth(DEPTH), .RepW(REPW), .ELEN(ELEN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_reps_i  (cmd_reps_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .bc_valid_o  (bc_valid_o),
        .bc_ready_i  (bc_ready_i),
        .bc_data_o   (bc_data_o),
        .ret_valid_i (ret_valid_i),
        .ret_ready_o (ret_ready_o),
        .ret_data_i  (ret_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'(1));
        check({tag, "_busy"},      64'(busy_o),      64'(0));
        check({tag, "_in_ready"},  64'(in_ready_o),  64'(0));
        check({tag, "_bc_valid"},  64'(bc_valid_o),  64'(0));
        check({tag, "_ret_ready"}, 64'(ret_ready_o), 64'(0));
    endtask

    // Runs one command from a negedge in IDLE; the chain is a fixed-delay FIFO.
    task automatic run_cmd(input int len, input int reps, input logic [63:0] base,
                           input int bc_mode, input int fill_mode, input int corrupt,
                           input int delay, output int sends, output int rets,
                           output logic err_end);
        logic [63:0] data [DEPTH];
        flight_t     q [$];
        int          total, filled, sent, returned, stall_left, c;
        bit          stalled, finished;
        logic        err_m, exp_bcv, in_f, bc_f, ret_f;
        logic [63:0] rd, bcd;

        total = len * (reps + 1);
        filled = 0; sent = 0; returned = 0; stall_left = 0; c = 0;
        stalled = 0; err_m = 1'b0; rd = '0;
        for (int i = 0; i < int'(DEPTH); i++) data[i] = base + 64'(i);

        check("cmd_ready_before", 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1;
        cmd_len_i   = 4'(len);
        cmd_reps_i  = 8'(reps);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        finished = (len == 0);

        while (!finished && c < 3000) begin
            exp_bcv = (sent < total) && ((sent < filled) || (sent >= len));
            check("busy",      64'(busy_o),      64'(1));
            check("cmd_ready", 64'(cmd_ready_o), 64'(0));
            check("done_low",  64'(done_o),      64'(0));
            check("in_ready",  64'(in_ready_o),  64'(filled < len));
            check("bc_valid",  64'(bc_valid_o),  64'(exp_bcv));
            check("ret_ready", 64'(ret_ready_o), 64'(1));
            check("err",       64'(err_o),       64'(err_m));
            if (bc_valid_o && exp_bcv) check("bc_data", bc_data_o, data[sent % len]);

            if (fill_mode == 1 && filled == 2 && !stalled) begin
                stalled = 1;
                stall_left = 3;
            end
            case (fill_mode)
                1:       in_valid_i = (filled < len) && (stall_left == 0);
                2:       in_valid_i = (filled < len) && ($urandom_range(0, 1) == 1);
                default: in_valid_i = (filled < len);
            endcase
            if (stall_left > 0) stall_left--;
            in_data_i = (filled < len) ? data[filled] : '0;

            case (bc_mode)
                1:       bc_ready_i = (c % 2 == 0);
                2:       bc_ready_i = ($urandom_range(0, 1) == 1);
                default: bc_ready_i = 1'b1;
            endcase

            if (q.size() > 0 && q[0].due <= c) begin
                rd = q[0].d ^ ((returned == corrupt) ? 64'd1 : 64'd0);
                ret_valid_i = 1'b1;
                ret_data_i  = rd;
            end else begin
                ret_valid_i = 1'b0;
                ret_data_i  = '0;
            end

            in_f  = in_valid_i && in_ready_o;
            bc_f  = bc_valid_o && bc_ready_i;
            ret_f = ret_valid_i && ret_ready_o;
            bcd   = bc_data_o;

            @(posedge clk_i);
            if (in_f) filled++;
            if (bc_f) begin
                q.push_back('{d: bcd, due: c + delay});
                sent++;
            end
            if (ret_f) begin
                if (rd != data[returned % len]) err_m = 1'b1;
                void'(q.pop_front());
                returned++;
                if (returned == total) finished = 1;
            end
            @(negedge clk_i);
            c++;
        end
        if (!finished) check("cmd_timeout", 64'(0), 64'(1));

        in_valid_i = 1'b0; bc_ready_i = 1'b0; ret_valid_i = 1'b0;
        check("done_pulse", 64'(done_o), 64'(1));
        check("err_at_done", 64'(err_o), 64'(err_m));
        check_idle("done_cycle");
        err_end = err_o;
        @(negedge clk_i);
        check("done_one_cycle", 64'(done_o), 64'(0));
        check("idle_after_done", 64'(cmd_ready_o), 64'(1));
        sends = sent;
        rets  = returned;
    endtask

    initial begin
        vec_t        tbl [7];
        int          s, r, l, rp, tot, corr, filled, sent;
        logic        e;
        logic        in_f, bc_f;
        logic [63:0] d5 [5];

        tbl[0] = '{4, 0, 64'hA0,  0, 0, -1, 4, 4,  1'b0};  // single pass
        tbl[1] = '{3, 2, 64'd10,  0, 0, -1, 4, 9,  1'b0};  // replay
        tbl[2] = '{8, 0, 64'd100, 1, 1, -1, 3, 8,  1'b0};  // backpressure + fill stall
        tbl[3] = '{4, 0, 64'd200, 0, 0, 1,  4, 4,  1'b1};  // 2nd return corrupted
        tbl[4] = '{0, 0, 64'd0,   0, 0, -1, 4, 0,  1'b0};  // zero length
        tbl[5] = '{8, 3, 64'd300, 2, 2, -1, 5, 32, 1'b0};
        tbl[6] = '{1, 0, 64'd400, 0, 0, 0,  1, 1,  1'b1};

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_len_i = '0; cmd_reps_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; bc_ready_i = 1'b0;
        ret_valid_i = 1'b0; ret_data_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check_idle("reset");
        check("reset_done", 64'(done_o), 64'(0));
        check("reset_err",  64'(err_o),  64'(0));

        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i].len, tbl[i].reps, tbl[i].base, tbl[i].bc_mode, tbl[i].fill_mode,
                    tbl[i].corrupt, tbl[i].delay, s, r, e);
            check("tbl_sends",   64'(s), 64'(tbl[i].exp_sends));
            check("tbl_returns", 64'(r), 64'(tbl[i].exp_sends));
            check("tbl_err",     64'(e), 64'(tbl[i].exp_err));
        end

        // Command held valid across a whole len=1 command, then a reset mid-command.
        cmd_valid_i = 1'b1; cmd_len_i = 4'd1; cmd_reps_i = '0;
        in_valid_i = 1'b1; in_data_i = 64'h5A5A; bc_ready_i = 1'b1;
        @(negedge clk_i);
        check("hold_busy",       64'(busy_o),      64'(1));
        check("hold_cmd_ready0", 64'(cmd_ready_o), 64'(0));
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("hold_bc_valid",   64'(bc_valid_o),  64'(1));
        check("hold_bc_data",    bc_data_o,        64'h5A5A);
        check("hold_cmd_ready1", 64'(cmd_ready_o), 64'(0));
        @(negedge clk_i);
        check("hold_bc_valid_off", 64'(bc_valid_o),  64'(0));
        check("hold_cmd_ready2",   64'(cmd_ready_o), 64'(0));
        ret_valid_i = 1'b1; ret_data_i = 64'h5A5A;
        @(negedge clk_i);
        ret_valid_i = 1'b0;
        check("hold_done",      64'(done_o),      64'(1));
        check("hold_done_busy", 64'(busy_o),      64'(0));
        check("hold_done_err",  64'(err_o),       64'(0));
        check("hold_done_cmdr", 64'(cmd_ready_o), 64'(1));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("hold_second_accept", 64'(busy_o), 64'(1));
        check("hold_second_done",   64'(done_o), 64'(0));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_idle("hold_reset");
        check("hold_reset_done", 64'(done_o), 64'(0));

        // Reset after 2 of 5 sends, with a return still offered.
        for (int i = 0; i < 5; i++) d5[i] = 64'hC0 + 64'(i);
        cmd_valid_i = 1'b1; cmd_len_i = 4'd5; cmd_reps_i = '0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; in_valid_i = 1'b1; bc_ready_i = 1'b1;
        filled = 0; sent = 0;
        for (int k = 0; k < 20 && sent < 2; k++) begin
            in_data_i = (filled < 5) ? d5[filled] : '0;
            in_f = in_valid_i && in_ready_o;
            bc_f = bc_valid_o && bc_ready_i;
            @(negedge clk_i);
            if (in_f) filled++;
            if (bc_f) sent++;
        end
        check("abort_sent", 64'(sent), 64'(2));
        in_valid_i = 1'b0; bc_ready_i = 1'b0;
        ret_valid_i = 1'b1; ret_data_i = d5[0];
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_idle("abort");
        check("abort_done", 64'(done_o), 64'(0));
        check("abort_err",  64'(err_o),  64'(0));
        @(negedge clk_i);
        check("abort_no_done", 64'(done_o),      64'(0));
        check("abort_no_ret",  64'(ret_ready_o), 64'(0));
        ret_valid_i = 1'b0;
        run_cmd(1, 0, 64'hD0, 0, 0, -1, 2, s, r, e);
        check("after_abort_sends", 64'(s), 64'(1));
        check("after_abort_err",   64'(e), 64'(0));

        for (int i = 0; i < 15; i++) begin
            l    = int'($urandom_range(0, 8));
            rp   = int'($urandom_range(0, 3));
            tot  = l * (rp + 1);
            corr = (tot > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run_cmd(l, rp, 64'($urandom) << 8, 2, 2, corr, int'($urandom_range(1, 6)), s, r, e);
            check("rand_sends",   64'(s), 64'(tot));
            check("rand_returns", 64'(r), 64'(tot));
            check("rand_err",     64'(e), 64'(corr >= 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
